// File: rtl/dbus_dual_sequencer.sv
// rtl/dbus_dual_sequencer.sv - serialises two memory-stage slots onto one data-bus port
// Slot 1 (older) is always issued before slot 0; one access outstanding at a time.
module dbus_dual_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [5:0]              req_size,
  input  logic [2*(DATA_W/8)-1:0] req_strobe,
  input  logic [2*DATA_W-1:0]     req_data,
  input  logic                    kill0,
  input  logic                    advance,
  input  logic                    flush,
  output logic                    dbus_valid,
  output logic [ADDR_W-1:0]       dbus_addr,
  output logic [2:0]              dbus_size,
  output logic [DATA_W/8-1:0]     dbus_strobe,
  output logic [DATA_W-1:0]       dbus_data,
  input  logic                    dbus_addr_ok,
  input  logic                    dbus_data_ok,
  input  logic [DATA_W-1:0]       dbus_rdata,
  output logic [2*DATA_W-1:0]     resp_data,
  output logic                    stall
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ0, WAIT0, DONE, DRAIN} state_t;

  state_t            state;
  logic              need0_r;
  logic              need1;
  logic              need0;
  logic              sel1;
  logic [ADDR_W-1:0] nxt_addr;
  logic [2:0]        nxt_size;
  logic [SW-1:0]     nxt_strobe;
  logic [DATA_W-1:0] nxt_data;

  assign need1 = req_valid[1];
  assign need0 = req_valid[0] & ~kill0;

  // Slot 1 is only ever loaded from IDLE; every other load is slot 0.
  assign sel1 = (state == IDLE) && need1;

  always_comb begin
    nxt_addr   = sel1 ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    nxt_size   = sel1 ? req_size[3 +: 3]           : req_size[0 +: 3];
    nxt_strobe = sel1 ? req_strobe[SW +: SW]       : req_strobe[0 +: SW];
    nxt_data   = sel1 ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
  end

  // Stall is decoded from the state so the pipeline is held in the very cycle a need appears.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:                    stall = need1 | need0;
      REQ1, WAIT1, REQ0, WAIT0: stall = 1'b1;
      DRAIN:                   stall = |req_valid;
      default:                 stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      need0_r     <= 1'b0;
      dbus_valid  <= 1'b0;
      dbus_addr   <= '0;
      dbus_size   <= '0;
      dbus_strobe <= '0;
      dbus_data   <= '0;
      resp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && (need1 || need0)) begin
            dbus_valid  <= 1'b1;
            dbus_addr   <= nxt_addr;
            dbus_size   <= nxt_size;
            dbus_strobe <= nxt_strobe;
            dbus_data   <= nxt_data;
            need0_r     <= need0;
            state       <= need1 ? REQ1 : REQ0;
          end
        end
        REQ1, WAIT1: begin
          if (flush) begin
            dbus_valid <= 1'b0;
            if (state == REQ1 && !dbus_addr_ok) state <= IDLE;
            else                                state <= dbus_data_ok ? IDLE : DRAIN;
          end else if (state == REQ1 && dbus_addr_ok && !dbus_data_ok) begin
            dbus_valid <= 1'b0;
            state      <= WAIT1;
          end else if ((state == WAIT1 || dbus_addr_ok) && dbus_data_ok) begin
            resp_data[DATA_W +: DATA_W] <= dbus_rdata;
            if (need0_r) begin
              dbus_valid  <= 1'b1;
              dbus_addr   <= nxt_addr;
              dbus_size   <= nxt_size;
              dbus_strobe <= nxt_strobe;
              dbus_data   <= nxt_data;
              state       <= REQ0;
            end else begin
              dbus_valid <= 1'b0;
              state      <= DONE;
            end
          end
        end
        REQ0, WAIT0: begin
          if (flush) begin
            dbus_valid <= 1'b0;
            if (state == REQ0 && !dbus_addr_ok) state <= IDLE;
            else                                state <= dbus_data_ok ? IDLE : DRAIN;
          end else if (state == REQ0 && kill0 && !dbus_addr_ok) begin
            dbus_valid <= 1'b0;
            state      <= DONE;
          end else if (state == REQ0 && dbus_addr_ok && !dbus_data_ok) begin
            dbus_valid <= 1'b0;
            state      <= WAIT0;
          end else if ((state == WAIT0 || dbus_addr_ok) && dbus_data_ok) begin
            resp_data[0 +: DATA_W] <= dbus_rdata;
            dbus_valid             <= 1'b0;
            state                  <= DONE;
          end
        end
        DONE: begin
          if (advance || flush) state <= IDLE;
        end
        DRAIN: begin
          if (dbus_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
